// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, register index type and zero-register constant
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);
  typedef logic [AW_DEF-1:0] reg_idx_t;
  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register write-pending bits with issue-set / writeback-clear
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [NRD*AW-1:0] ra,
  output logic [NREG-1:0]   busy,
  output logic [NRD-1:0]    rd_busy_raw
);
  logic [NREG-1:0] busy_q, busy_d;
  // a new producer issued in the cycle the old one retires keeps the bit set
  always_comb begin
    busy_d = '0;
    for (int i = 1; i < NREG; i++)
      busy_d[i] = (iss_valid && iss_rd == AW'(i)) | (busy_q[i] & ~(we && wa == AW'(i)));
  end
  // busy vector register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy_q <= '0;
    else busy_q <= busy_d;
  assign busy = busy_q;
  for (genvar p = 0; p < NRD; p++) begin : gen_port
    assign rd_busy_raw[p] = busy_q[ra[p*AW +: AW]];
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with hardwired x0, write bypass and busy scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic [NREG-1:0]     busy
);
  logic [XLEN-1:0] mem_q [1:NREG-1];
  logic            wr_d;
  logic [NRD-1:0]  rd_busy_raw;
  assign wr_d = we && wa != AW'(REG_ZERO);
  // storage for x1..x(NREG-1); x0 has no flops
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 1; i < NREG; i++) mem_q[i] <= '0;
    else if (wr_d) mem_q[wa] <= wd;
  regfile_scoreboard #(.NREG(NREG), .NRD(NRD)) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid   (iss_valid),
    .iss_rd      (iss_rd),
    .we          (we),
    .wa          (wa),
    .ra          (ra),
    .busy        (busy),
    .rd_busy_raw (rd_busy_raw)
  );
  for (genvar p = 0; p < NRD; p++) begin : gen_rd
    logic [AW-1:0] a;
    logic          hit;
    assign a   = ra[p*AW +: AW];
    // the write is ignored during reset, so it must not leak through the bypass either
    assign hit = (BYPASS != 0) && rst_n && wr_d && wa == a;
    assign rd[p*XLEN +: XLEN] = a == AW'(REG_ZERO) ? '0 : hit ? wd : mem_q[a];
    assign rd_busy[p] = rd_busy_raw[p] & ~hit;
  end
endmodule
